// File: rtl/plb_debug_dump_sequencer.sv
// plb_debug_dump_sequencer
// Walks a latched channel mask, dumping each selected shadow chain into a
// tagged show-ahead capture FIFO that the PLB slave drains. Handles FIFO
// backpressure, per-channel timeout and error-injection control to the chains.
module plb_debug_dump_sequencer #(
   parameter int NUM_CH      = 32,
   parameter int DW          = 32,
   parameter int CTRL_W      = 12,
   parameter int FIFO_DEPTH  = 16,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                          gclk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [NUM_CH-1:0]             ch_mask,
   input  logic                          err_req,
   input  logic [CTRL_W-1:0]             err_mode_in,
   output logic                          busy,
   output logic                          done,
   output logic                          timeout_err,
   output logic                          sh_rst,
   output logic                          c_en,
   output logic [NUM_CH-1:0]             dump_en,
   output logic                          err_en,
   output logic [CTRL_W-1:0]             err_ctrl,
   input  logic [DW-1:0]                 sh_out,
   input  logic [NUM_CH-1:0]             sh_out_vld,
   input  logic [NUM_CH-1:0]             sh_out_done,
   input  logic                          rd_en,
   output logic                          rd_valid,
   output logic [DW-1:0]                 rd_data,
   output logic [$clog2(NUM_CH)-1:0]     rd_ch,
   output logic                          rd_last,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

   localparam int CHW = $clog2(NUM_CH);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int TW  = $clog2(TIMEOUT_CYC + 1);
   localparam int EW  = DW + CHW + 1;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RST  = 3'd1;
   localparam logic [2:0] S_SEL  = 3'd2;
   localparam logic [2:0] S_SCAN = 3'd3;
   localparam logic [2:0] S_FIN  = 3'd4;

   logic [2:0]        state_reg;
   logic [NUM_CH-1:0] mask_reg;
   logic              err_req_reg;
   logic [CTRL_W-1:0] err_mode_reg;
   logic [CHW-1:0]    ch_reg;
   logic [TW-1:0]     tmo_cnt_reg;
   logic              timeout_err_reg;
   logic [AW-1:0]     wr_ptr_reg;
   logic [AW-1:0]     rd_ptr_reg;
   logic [AW:0]       cnt_reg;
   logic [EW-1:0]     mem [FIFO_DEPTH];

   logic              sel_found;
   logic [CHW-1:0]    sel_idx;
   logic              in_scan;
   logic              fifo_full;
   logic              cur_vld;
   logic              cur_done;
   logic              push;
   logic              pop;
   logic              chan_end;
   logic              tmo_hit;
   logic              err_active;
   logic [EW-1:0]     head;

   // Lowest set bit of the remaining mask (scan from the top so the lowest wins)
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask_reg[i]) begin
            sel_found = 1'b1;
            sel_idx   = CHW'(i);
         end
      end
   end

   assign in_scan   = (state_reg == S_SCAN);
   assign fifo_full = (cnt_reg == (AW+1)'(FIFO_DEPTH));
   assign c_en      = in_scan && !fifo_full;
   assign cur_vld   = sh_out_vld[ch_reg];
   assign cur_done  = sh_out_done[ch_reg];
   assign push      = c_en && cur_vld;
   assign pop       = rd_en && (cnt_reg != '0);
   assign chan_end  = c_en && cur_done;
   // Timeout fires on the TIMEOUT_CYC-th enabled cycle with nothing accepted
   assign tmo_hit   = c_en && !cur_vld && !cur_done && (tmo_cnt_reg == TW'(TIMEOUT_CYC - 1));

   // Sequencer FSM: latch the request, walk the mask, track per-channel timeout
   always_ff @(posedge gclk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= S_IDLE;
         mask_reg        <= '0;
         err_req_reg     <= 1'b0;
         err_mode_reg    <= '0;
         ch_reg          <= '0;
         tmo_cnt_reg     <= '0;
         timeout_err_reg <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  mask_reg        <= ch_mask;
                  err_req_reg     <= err_req;
                  err_mode_reg    <= err_mode_in;
                  timeout_err_reg <= 1'b0;
                  state_reg       <= S_RST;
               end
            end
            S_RST: state_reg <= S_SEL;
            S_SEL: begin
               if (sel_found) begin
                  ch_reg            <= sel_idx;
                  mask_reg[sel_idx] <= 1'b0;
                  tmo_cnt_reg       <= '0;
                  state_reg         <= S_SCAN;
               end else begin
                  state_reg <= S_FIN;
               end
            end
            S_SCAN: begin
               if (chan_end) begin
                  state_reg <= S_SEL;
               end else if (push) begin
                  tmo_cnt_reg <= '0;
               end else if (tmo_hit) begin
                  timeout_err_reg <= 1'b1;
                  state_reg       <= S_SEL;
               end else if (c_en) begin
                  tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
               end
            end
            S_FIN:   state_reg <= S_IDLE;
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   // Capture FIFO pointers and occupancy; contents are simply abandoned on reset
   always_ff @(posedge gclk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         cnt_reg    <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   cnt_reg <= cnt_reg + 1'b1;
            2'b01:   cnt_reg <= cnt_reg - 1'b1;
            default: cnt_reg <= cnt_reg;
         endcase
      end
   end

   // FIFO storage write: {word, channel tag, last flag}
   always_ff @(posedge gclk) begin
      if (push) mem[wr_ptr_reg] <= {sh_out, ch_reg, cur_done};
   end

   // One-hot channel select, only while scanning
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_dump_en
      assign dump_en[gi] = in_scan && (ch_reg == CHW'(gi));
   end

   assign err_active  = (state_reg == S_RST) || (state_reg == S_SEL) || in_scan;
   assign busy        = (state_reg != S_IDLE);
   assign done        = (state_reg == S_FIN);
   assign sh_rst      = (state_reg == S_RST);
   assign err_en      = err_active && err_req_reg;
   assign err_ctrl    = err_active ? err_mode_reg : '0;
   assign timeout_err = timeout_err_reg;

   // Show-ahead head; fields forced to zero while empty so stale entries never leak out
   assign head     = mem[rd_ptr_reg];
   assign rd_valid = (cnt_reg != '0);
   assign rd_data  = rd_valid ? head[EW-1 -: DW] : '0;
   assign rd_ch    = rd_valid ? head[CHW:1] : '0;
   assign rd_last  = rd_valid && head[0];
   assign fifo_cnt = cnt_reg;

endmodule
